// File: rtl/uart_move_pkg.sv
// Shared definitions for the Gobang move frame codec: frame header byte,
// receive/transmit state encodings and the frame checksum helper.
package uart_move_pkg;

    localparam logic [7:0] MOVE_HDR = 8'hA5;

    typedef enum logic [1:0] {
        RX_HUNT    = 2'd0,
        RX_GET_X   = 2'd1,
        RX_GET_Y   = 2'd2,
        RX_GET_SUM = 2'd3
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_HDR  = 3'd1,
        TX_SX   = 3'd2,
        TX_SY   = 3'd3,
        TX_SUM  = 3'd4
    } tx_state_e;

    // Frame checksum: header XOR x XOR y.
    function automatic logic [7:0] move_checksum(input logic [7:0] x, input logic [7:0] y);
        return MOVE_HDR ^ x ^ y;
    endfunction

endpackage

// File: rtl/uart_move_tx_framer.sv
// Transmit side of the move codec: latches a move, then writes the four
// frame bytes into the transmit FIFO, stalling whenever the FIFO is full.
module uart_move_tx_framer #(
    parameter int COORD_W = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               tx_send,
    input  logic [COORD_W-1:0] tx_x,
    input  logic [COORD_W-1:0] tx_y,
    input  logic               txd_full,
    output logic [7:0]         txd_data,
    output logic               txd_wr_en,
    output logic               tx_ready
);
    import uart_move_pkg::*;

    tx_state_e  state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;

    // Next-state logic: accept a move only when idle, advance one byte per accepted write.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            TX_IDLE: begin
                if (tx_send) begin
                    x_d     = 8'(tx_x);
                    y_d     = 8'(tx_y);
                    state_d = TX_HDR;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_HDR: begin
                if (!txd_full) state_d = TX_SX;  else state_d = TX_HDR;
            end
            TX_SX: begin
                if (!txd_full) state_d = TX_SY;  else state_d = TX_SX;
            end
            TX_SY: begin
                if (!txd_full) state_d = TX_SUM; else state_d = TX_SY;
            end
            TX_SUM: begin
                if (!txd_full) state_d = TX_IDLE; else state_d = TX_SUM;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // Byte selection for the current frame position; zero while idle.
    always_comb begin
        txd_data = 8'h00;
        case (state_q)
            TX_HDR:  txd_data = MOVE_HDR;
            TX_SX:   txd_data = x_q;
            TX_SY:   txd_data = y_q;
            TX_SUM:  txd_data = move_checksum(x_q, y_q);
            default: txd_data = 8'h00;
        endcase
    end

    // The write strobe follows txd_full in the same cycle so no byte is ever pushed into a full FIFO.
    assign txd_wr_en = (state_q != TX_IDLE) && !txd_full;
    assign tx_ready  = (state_q == TX_IDLE);

    // State and latched coordinate registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= TX_IDLE;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: rtl/uart_move_link.sv
// Gobang move frame codec between the UART FIFO wrapper and the game logic.
// Receive: drains the RX FIFO one byte per two cycles, parses A5/x/y/sum
// frames and reports validated moves. Transmit: see uart_move_tx_framer.
// Optional macro UART_MOVE_TIMEOUT_EN adds an inter-byte timeout that drops
// a stalled partial frame and counts it as an error.
module uart_move_link #(
    parameter int BOARD_SIZE     = 15,
    parameter int COORD_W        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [7:0]         rxd_data,
    input  logic               rxd_empty,
    output logic               rxd_rd_en,
    output logic [7:0]         txd_data,
    output logic               txd_wr_en,
    input  logic               txd_full,
    output logic               rx_valid,
    output logic [COORD_W-1:0] rx_x,
    output logic [COORD_W-1:0] rx_y,
    output logic [7:0]         rx_err_cnt,
    input  logic               tx_send,
    input  logic [COORD_W-1:0] tx_x,
    input  logic [COORD_W-1:0] tx_y,
    output logic               tx_ready
);
    import uart_move_pkg::*;

    localparam logic [7:0] BOARD_LIM = 8'(BOARD_SIZE);

    logic               rd_en_q, rd_en_d;
    logic               dv_q;
    rx_state_e          rx_state_q, rx_state_d;
    logic [7:0]         x_buf_q, x_buf_d;
    logic [7:0]         y_buf_q, y_buf_d;
    logic [COORD_W-1:0] rx_x_q, rx_x_d;
    logic [COORD_W-1:0] rx_y_q, rx_y_d;
    logic               rx_valid_q, rx_valid_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               err_inc_s;
    logic               frame_ok_s;
    logic               timeout_s;

`ifdef UART_MOVE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Inter-byte timer: restarts on every sampled byte, runs only inside a frame.
    always_comb begin
        to_cnt_d  = '0;
        timeout_s = 1'b0;
        if (dv_q) begin
            to_cnt_d = '0;
        end else if (rx_state_q != RX_HUNT) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_s = 1'b1;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Timer register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    // Without the timer a partial frame simply waits; the length is kept only for interface parity.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_s = 1'b0;
`endif

    // A frame is good only if the checksum matches and both full 8-bit coordinates are on the board.
    assign frame_ok_s = (rxd_data == move_checksum(x_buf_q, y_buf_q)) &&
                        (x_buf_q < BOARD_LIM) && (y_buf_q < BOARD_LIM);

    // Read strobe: one read in flight at a time; a strobe this cycle blocks the next one.
    always_comb begin
        if (!rxd_empty && !rd_en_q) rd_en_d = 1'b1;
        else                        rd_en_d = 1'b0;
    end

    // Receive parser: consumes a byte on the cycle after its read strobe.
    always_comb begin
        rx_state_d = rx_state_q;
        x_buf_d    = x_buf_q;
        y_buf_d    = y_buf_q;
        rx_x_d     = rx_x_q;
        rx_y_d     = rx_y_q;
        rx_valid_d = 1'b0;
        err_inc_s  = 1'b0;
        if (dv_q) begin
            case (rx_state_q)
                RX_HUNT: begin
                    if (rxd_data == MOVE_HDR) rx_state_d = RX_GET_X;
                    else                      rx_state_d = RX_HUNT;
                end
                RX_GET_X: begin
                    x_buf_d    = rxd_data;
                    rx_state_d = RX_GET_Y;
                end
                RX_GET_Y: begin
                    y_buf_d    = rxd_data;
                    rx_state_d = RX_GET_SUM;
                end
                RX_GET_SUM: begin
                    if (frame_ok_s) begin
                        rx_x_d     = x_buf_q[COORD_W-1:0];
                        rx_y_d     = y_buf_q[COORD_W-1:0];
                        rx_valid_d = 1'b1;
                    end else begin
                        err_inc_s  = 1'b1;
                    end
                    rx_state_d = RX_HUNT;
                end
                default: rx_state_d = RX_HUNT;
            endcase
        end else if (timeout_s) begin
            err_inc_s  = 1'b1;
            rx_state_d = RX_HUNT;
        end else begin
            rx_state_d = rx_state_q;
        end
    end

    // Rejected-frame counter saturates at 255.
    always_comb begin
        if (err_inc_s && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        else                                   err_cnt_d = err_cnt_q;
    end

    // Receive-side registers with synchronous reset; a reset drops any partial frame and pending read.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_en_q    <= 1'b0;
            dv_q       <= 1'b0;
            rx_state_q <= RX_HUNT;
            x_buf_q    <= 8'h00;
            y_buf_q    <= 8'h00;
            rx_x_q     <= '0;
            rx_y_q     <= '0;
            rx_valid_q <= 1'b0;
            err_cnt_q  <= 8'h00;
        end else begin
            rd_en_q    <= rd_en_d;
            dv_q       <= rd_en_q;
            rx_state_q <= rx_state_d;
            x_buf_q    <= x_buf_d;
            y_buf_q    <= y_buf_d;
            rx_x_q     <= rx_x_d;
            rx_y_q     <= rx_y_d;
            rx_valid_q <= rx_valid_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rxd_rd_en  = rd_en_q;
    assign rx_valid   = rx_valid_q;
    assign rx_x       = rx_x_q;
    assign rx_y       = rx_y_q;
    assign rx_err_cnt = err_cnt_q;

    uart_move_tx_framer #(
        .COORD_W (COORD_W)
    ) u_tx_framer (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tx_send   (tx_send),
        .tx_x      (tx_x),
        .tx_y      (tx_y),
        .txd_full  (txd_full),
        .txd_data  (txd_data),
        .txd_wr_en (txd_wr_en),
        .tx_ready  (tx_ready)
    );

endmodule

// File: tb/tb_uart_move_link.sv
// Self-checking bench for uart_move_link: table-driven receive vectors,
// hand-written transmit/reset/latency sequences, and a randomized phase
// checked against a frame-scanning reference model.
module tb_uart_move_link;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] rxd_data = 8'h00;
    logic       rxd_empty = 1'b1;
    logic       rxd_rd_en;
    logic [7:0] txd_data;
    logic       txd_wr_en;
    logic       txd_full = 1'b0;
    logic       rx_valid;
    logic [3:0] rx_x, rx_y;
    logic [7:0] rx_err_cnt;
    logic       tx_send = 1'b0;
    logic [3:0] tx_x = 4'd0, tx_y = 4'd0;
    logic       tx_ready;

    uart_move_link #(.BOARD_SIZE(15), .COORD_W(4), .TIMEOUT_CYCLES(100)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .rxd_data(rxd_data), .rxd_empty(rxd_empty), .rxd_rd_en(rxd_rd_en),
        .txd_data(txd_data), .txd_wr_en(txd_wr_en), .txd_full(txd_full),
        .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y), .rx_err_cnt(rx_err_cnt),
        .tx_send(tx_send), .tx_x(tx_x), .tx_y(tx_y), .tx_ready(tx_ready)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int underflow = 0;
    int thr_viol = 0;
    int wr_full_viol = 0;
    int last_rd = -10;
    int valid_lat = -1;

    logic [7:0] rxq[$];
    logic [3:0] rx_mx[$], rx_my[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    logic [7:0] sb[$];
    logic [3:0] exp_mx[$], exp_my[$];
    logic [7:0] exp_tx[$];
    int         exp_err;
    bit         tx_done;

    typedef struct {
        logic [63:0] bytes;
        int          len;
        int          nmov;
        logic [3:0]  ex;
        logic [3:0]  ey;
        logic [7:0]  eerr;
    } rx_vec_t;
    rx_vec_t vt[8];

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Standard-mode receive FIFO: data valid the cycle after the read strobe.
    always @(posedge sys_clk) begin
        if (rxd_rd_en) begin
            if (rxq.size() > 0) rxd_data <= rxq.pop_front();
            else underflow++;
        end
        rxd_empty <= (rxq.size() == 0);
    end

    // Output monitor sampled on the falling edge.
    always @(negedge sys_clk) begin
        if (rxd_rd_en) begin
            if (cyc - last_rd < 2) thr_viol++;
            last_rd = cyc;
        end
        if (rx_valid) begin
            rx_mx.push_back(rx_x);
            rx_my.push_back(rx_y);
            valid_lat = cyc - last_rd;
        end
        if (txd_wr_en) begin
            tx_log.push_back(txd_data);
            tx_cyc.push_back(cyc);
            if (txd_full) wr_full_viol++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        rx_mx.delete(); rx_my.delete(); tx_log.delete(); tx_cyc.delete();
        valid_lat = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_en"}, rxd_rd_en, 0);
        check({tag, "_wr_en"}, txd_wr_en, 0);
        check({tag, "_txd_data"}, txd_data, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_rx_x"}, rx_x, 0);
        check({tag, "_rx_y"}, rx_y, 0);
        check({tag, "_err"}, rx_err_cnt, 0);
        check({tag, "_tx_ready"}, tx_ready, 1);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        clear_logs();
    endtask

    task automatic push_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s);
        rxq.push_back(8'hA5); rxq.push_back(x); rxq.push_back(y); rxq.push_back(s);
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (rxq.size() != 0 && k < limit) begin
            tick(1);
            k++;
        end
        if (rxq.size() != 0) begin
            checks++; errors++;
            $display("FAIL rx_drain actual=%0d_left expected=0", rxq.size());
        end
        tick(6);
    endtask

    task automatic wait_ready(input int limit);
        int k = 0;
        while (!tx_ready && k < limit) begin
            tick(1);
            k++;
        end
        check("tx_ready_wait", tx_ready, 1);
    endtask

    // Reference receiver: scan for a header, take the next three bytes as a frame, never rescan them.
    task automatic ref_rx();
        int i = 0;
        logic [7:0] x, y, s;
        exp_mx.delete(); exp_my.delete(); exp_err = 0;
        while (i < sb.size()) begin
            if (sb[i] != 8'hA5) begin
                i++;
            end else if (i + 3 < sb.size()) begin
                x = sb[i+1]; y = sb[i+2]; s = sb[i+3];
                if (s == (8'hA5 ^ x ^ y) && x < 15 && y < 15) begin
                    exp_mx.push_back(x[3:0]); exp_my.push_back(y[3:0]);
                end else begin
                    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                end
                i += 4;
            end else begin
                i = sb.size();
            end
        end
    endtask

    initial begin
        int t0;
        vt[0] = '{64'hA50307A1_00000000, 4, 1, 4'd3,  4'd7,  8'd0};
        vt[1] = '{64'h1122A503_07A10000, 6, 1, 4'd3,  4'd7,  8'd0};
        vt[2] = '{64'hA5030700_A50F00AA, 8, 0, 4'd0,  4'd0,  8'd2};
        vt[3] = '{64'hA50E0EA5_00000000, 4, 1, 4'd14, 4'd14, 8'd0};
        vt[4] = '{64'hA5000FAA_00000000, 4, 0, 4'd0,  4'd0,  8'd1};
        vt[5] = '{64'hA5A50307_A1000000, 5, 0, 4'd0,  4'd0,  8'd1};
        vt[6] = '{64'hA50A05AA_00000000, 4, 1, 4'd10, 4'd5,  8'd0};
        vt[7] = '{64'hA51300B6_00000000, 4, 0, 4'd0,  4'd0,  8'd1};

        // Power-on reset values.
        sys_rst = 1'b1;
        tick(2);
        check_reset_vals("por");
        sys_rst = 1'b0;
        tick(1);

        // Receive vectors, each from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            for (int j = 0; j < vt[i].len; j++) rxq.push_back(vt[i].bytes[63-8*j -: 8]);
            wait_drain(100);
            check($sformatf("vec%0d_nmov", i), rx_mx.size(), vt[i].nmov);
            check($sformatf("vec%0d_x", i), rx_x, vt[i].ex);
            check($sformatf("vec%0d_y", i), rx_y, vt[i].ey);
            check($sformatf("vec%0d_err", i), rx_err_cnt, vt[i].eerr);
        end

        // Receive latency: checksum read strobe to rx_valid is two cycles.
        do_reset();
        push_frame(8'h02, 8'h06, 8'hA1);
        wait_drain(100);
        check("lat_nmov", rx_mx.size(), 1);
        check("lat_cycles", valid_lat, 2);

        // Transmit with FIFO full for cycles t+2..t+4 and an ignored mid-frame request.
        do_reset();
        tx_x = 4'd14; tx_y = 4'd2; tx_send = 1'b1; t0 = cyc;
        tick(1);
        tx_send = 1'b0;
        check("tx_busy_t1", tx_ready, 0);
        tick(1); txd_full = 1'b1;
        tick(1); tx_send = 1'b1; tx_x = 4'd1; tx_y = 4'd1;
        tick(1); tx_send = 1'b0;
        tick(1); txd_full = 1'b0;
        tick(2);
        check("tx_busy_t7", tx_ready, 0);
        tick(1);
        check("tx_ready_t8", tx_ready, 1);
        tick(4);
        check("tx_stall_nbytes", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            check("tx_stall_b0", tx_log[0], 8'hA5);
            check("tx_stall_b1", tx_log[1], 8'h0E);
            check("tx_stall_b2", tx_log[2], 8'h02);
            check("tx_stall_b3", tx_log[3], 8'hA9);
            check("tx_stall_c0", tx_cyc[0] - t0, 1);
            check("tx_stall_c1", tx_cyc[1] - t0, 5);
            check("tx_stall_c3", tx_cyc[3] - t0, 7);
        end

        // Transmit without stalls, unchecked coordinate 15.
        clear_logs();
        tx_x = 4'd15; tx_y = 4'd15; tx_send = 1'b1; t0 = cyc;
        tick(1); tx_send = 1'b0;
        tick(3);
        check("tx_fast_busy_t4", tx_ready, 0);
        tick(1);
        check("tx_fast_ready_t5", tx_ready, 1);
        check("tx_fast_nbytes", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            check("tx_fast_b1", tx_log[1], 8'h0F);
            check("tx_fast_b3", tx_log[3], 8'hA5);
            check("tx_fast_c3", tx_cyc[3] - t0, 4);
        end

        // Reset mid-frame on both paths.
        do_reset();
        rxq.push_back(8'hA5); rxq.push_back(8'h03);
        txd_full = 1'b1; tx_x = 4'd3; tx_y = 4'd3; tx_send = 1'b1;
        tick(1); tx_send = 1'b0;
        tick(8);
        sys_rst = 1'b1;
        tick(1);
        txd_full = 1'b0;
        tick(1);
        check_reset_vals("midrst");
        sys_rst = 1'b0;
        tick(6);
        check("midrst_no_tx", tx_log.size(), 0);
        push_frame(8'h01, 8'h01, 8'hA5);
        wait_drain(100);
        check("midrst_nmov", rx_mx.size(), 1);
        check("midrst_x", rx_x, 1);
        check("midrst_y", rx_y, 1);
        check("midrst_err", rx_err_cnt, 0);

        // Partial-frame behaviour with and without the inter-byte timeout.
        do_reset();
        rxq.push_back(8'hA5); rxq.push_back(8'h02);
`ifdef UART_MOVE_TIMEOUT_EN
        tick(130);
        check("to_err", rx_err_cnt, 1);
        push_frame(8'h04, 8'h05, 8'hA4);
        wait_drain(100);
        check("to_nmov", rx_mx.size(), 1);
        check("to_x", rx_x, 4);
        check("to_y", rx_y, 5);
`else
        tick(150);
        check("noto_err", rx_err_cnt, 0);
        rxq.push_back(8'h07); rxq.push_back(8'hA0);
        wait_drain(100);
        check("noto_nmov", rx_mx.size(), 1);
        check("noto_x", rx_x, 2);
        check("noto_y", rx_y, 7);
`endif

        // Randomized concurrent receive and transmit against the reference model.
        do_reset();
        sb.delete(); exp_tx.delete(); tx_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] x, y, b;
            int r;
            r = $urandom_range(0, 5);
            x = 8'($urandom_range(0, 14)); y = 8'($urandom_range(0, 14));
            case (r)
                0: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'hA5) b = 8'h5A;
                    sb.push_back(b);
                end
                3: begin
                    sb.push_back(8'hA5); sb.push_back(x); sb.push_back(y);
                    sb.push_back(8'hA5 ^ x ^ y ^ 8'($urandom_range(1, 255)));
                end
                4: begin
                    if ($urandom_range(0, 1) == 0) x = 8'($urandom_range(15, 255));
                    else y = 8'($urandom_range(15, 255));
                    sb.push_back(8'hA5); sb.push_back(x); sb.push_back(y); sb.push_back(8'hA5 ^ x ^ y);
                end
                5: begin
                    x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255));
                    sb.push_back(8'hA5); sb.push_back(x); sb.push_back(y); sb.push_back(8'hA5 ^ x ^ y);
                end
                default: begin
                    sb.push_back(8'hA5); sb.push_back(x); sb.push_back(y); sb.push_back(8'hA5 ^ x ^ y);
                end
            endcase
        end
        ref_rx();
        fork
            begin
                for (int k = 0; k < sb.size(); k++) begin
                    rxq.push_back(sb[k]);
                    tick($urandom_range(0, 3));
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    logic [3:0] mx, my;
                    mx = 4'($urandom_range(0, 15)); my = 4'($urandom_range(0, 15));
                    wait_ready(200);
                    tx_x = mx; tx_y = my; tx_send = 1'b1;
                    exp_tx.push_back(8'hA5); exp_tx.push_back(8'(mx)); exp_tx.push_back(8'(my));
                    exp_tx.push_back(8'hA5 ^ 8'(mx) ^ 8'(my));
                    tick(1); tx_send = 1'b0;
                    tick($urandom_range(0, 4));
                end
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    txd_full = ($urandom_range(0, 3) == 0);
                    tick(1);
                end
                txd_full = 1'b0;
            end
        join
        wait_ready(200);
        wait_drain(2000);
        check("rand_nmov", rx_mx.size(), exp_mx.size());
        for (int k = 0; k < rx_mx.size() && k < exp_mx.size(); k++) begin
            check($sformatf("rand_x%0d", k), rx_mx[k], exp_mx[k]);
            check($sformatf("rand_y%0d", k), rx_my[k], exp_my[k]);
        end
        check("rand_err", rx_err_cnt, exp_err);
        check("rand_tx_nbytes", tx_log.size(), exp_tx.size());
        for (int k = 0; k < tx_log.size() && k < exp_tx.size(); k++)
            check($sformatf("rand_tx%0d", k), tx_log[k], exp_tx[k]);

        // Error counter saturation.
        do_reset();
        for (int k = 0; k < 260; k++) push_frame(8'h00, 8'h00, 8'h00);
        wait_drain(4000);
        check("sat_err", rx_err_cnt, 255);
        check("sat_nmov", rx_mx.size(), 0);
        push_frame(8'h01, 8'h01, 8'hA5);
        wait_drain(100);
        check("sat_after_nmov", rx_mx.size(), 1);
        check("sat_after_err", rx_err_cnt, 255);

        check("fifo_underflow", underflow, 0);
        check("rx_throughput", thr_viol, 0);
        check("wr_while_full", wr_full_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
